ssd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode seven-segment display.

---
 rtl/ssd_scan_ctrl_pkg.sv | 21 ++
 rtl/ssd_scan_ctrl_if.sv | 28 ++
 rtl/ssd_scan_ctrl_driver.sv | 31 +++
 rtl/ssd_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package ssd_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Active-low segments, so all-ones is a dark digit.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bus of the scan controller: enable, value load and the
// registered pin drives going back to the board.
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import ssd_scan_ctrl_pkg::*;

  localparam int IDX_W = clog2(NUM_DIGITS);

  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output en, value, load,
    input  an_n, seg, digit_idx, frame_done
  );

  modport slave (
    input  en, value, load,
    output an_n, seg, digit_idx, frame_done
  );

endinterface

// File: rtl/ssd_scan_ctrl_driver.sv
// Hex nibble to active-low seven-segment code, bit order {a,b,c,d,e,f,g}.
module ssd_driver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional build macro SSD_LZB_EN enables leading-zero blanking.
//
// state | meaning
// IDLE  | display dark, waiting for en
// BLANK | start of a digit slot, anodes off, seg already carries the new code
// SHOW  | remainder of the slot, anode of digit_idx driven low
//
// All pin outputs are computed from the next-cycle state and registered, so
// seg and an_n change together with digit_idx on the slot boundary.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  ssd_scan_ctrl_if.slave bus
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  active;
  logic [VAL_W-1:0]  shadow;
  logic              pending;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic [6:0]        seg_q;
  logic              frame_done_q;

  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [VAL_W-1:0]  active_nxt;
  logic              frame_wrap;
  logic [NUM_DIGITS-1:0] lit_mask;
  logic              lit_nxt;
  logic [3:0]        nibble_nxt;
  logic [6:0]        seg_dec;
  logic [NUM_DIGITS-1:0] an_nxt;

  // Frame boundary and the tear-free active-value update that rides on it.
  always_comb begin
    frame_wrap = bus.en && (state != IDLE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
    active_nxt = active;
    if (frame_wrap) begin
      if (bus.load)    active_nxt = bus.value;
      else if (pending) active_nxt = shadow;
    end
  end

  // Slot counter and digit index; the phase inside a slot follows the counter.
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    idx_nxt   = '0;
    if (bus.en) begin
      if (state != IDLE) begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          idx_nxt = idx;
        end
      end
      state_nxt = (int'(cnt_nxt) < BLANK_CYCLES) ? BLANK : SHOW;
    end
  end

`ifdef SSD_LZB_EN
  logic seen_nz;

  // A digit is lit if it or any more-significant digit is nonzero; digit 0 always.
  always_comb begin
    seen_nz  = 1'b0;
    lit_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (active_nxt[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lit_mask[i] = seen_nz || (i == 0);
    end
  end
`else
  assign lit_mask = '1;
`endif

  // Select the upcoming digit's nibble and anode pattern.
  always_comb begin
    nibble_nxt = 4'h0;
    lit_nxt    = 1'b0;
    an_nxt     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nibble_nxt = active_nxt[4*i +: 4];
        lit_nxt    = lit_mask[i];
        if (state_nxt == SHOW && lit_mask[i]) an_nxt[i] = 1'b0;
      end
    end
  end

  ssd_driver u_driver (
    .nibble (nibble_nxt),
    .seg    (seg_dec)
  );

  // Scan FSM, value registers and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      an_n_q       <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      active <= active_nxt;
      if (bus.load) begin
        shadow  <= bus.value;
        pending <= !frame_wrap;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
      an_n_q       <= an_nxt;
      seg_q        <= (state_nxt != IDLE && lit_nxt) ? seg_dec : SEG_BLANK;
      frame_done_q <= (state_nxt != IDLE) && (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.seg        = seg_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with N=4, R=8, B=2.
module tb_ssd_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
`ifdef SSD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  ssd_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  an_n;
    logic [6:0]  seg;
    logic [1:0]  idx;
    logic        fd;
  } vec_t;

  vec_t vecs [7];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic lit_of(input int d, input logic [15:0] v);
    return !LZB || (d == 0) || ((v >> (4 * d)) != 16'h0);
  endfunction

  // Frame cycle c: slot c/R, blank for the first B cycles, frame_done on the last.
  task automatic check_cycles(input string tag, input int start, input int n,
                              input logic [15:0] v, input int load_at, input logic [15:0] load_val);
    for (int c = start; c < start + n; c++) begin
      int d;
      int k;
      logic lit;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      if (c == load_at) begin
        bus.load  = 1'b1;
        bus.value = load_val;
      end
      tick();
      bus.load = 1'b0;
      d = c / R;
      k = c % R;
      lit = lit_of(d, v);
      exp_an  = (k >= B && lit) ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit ? enc(v[4*d +: 4]) : 7'h7F;
      check($sformatf("%s c%0d an_n", tag, c), 32'(bus.an_n), 32'(exp_an));
      check($sformatf("%s c%0d seg", tag, c), 32'(bus.seg), 32'(exp_seg));
      check($sformatf("%s c%0d idx", tag, c), 32'(bus.digit_idx), 32'(d));
      check($sformatf("%s c%0d frame_done", tag, c), 32'(bus.frame_done), 32'(c == N * R - 1));
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, " an_n"}, 32'(bus.an_n), 32'h0000_000F);
    check({tag, " seg"}, 32'(bus.seg), 32'h0000_007F);
    check({tag, " idx"}, 32'(bus.digit_idx), 32'h0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.load  = 1'b0;
    bus.value = 16'h0;

    //            rst   en    load  value     an_n  seg          idx   fd
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'hF, 7'b1111111, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h1234, 4'hF, 7'b1111111, 2'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h1234, 4'hF, 7'b1111111, 2'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'hF, 7'b1111111, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'hF, 7'b0000001, 2'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'hF, 7'b0000001, 2'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'hE, 7'b0000001, 2'd0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      rst_n    = vecs[i].rst_n;
      bus.en   = vecs[i].en;
      bus.load = vecs[i].load;
      if (vecs[i].load) bus.value = vecs[i].value;
      tick();
      bus.load = 1'b0;
      check($sformatf("vec%0d an_n", i), 32'(bus.an_n), 32'(vecs[i].an_n));
      check($sformatf("vec%0d seg", i), 32'(bus.seg), 32'(vecs[i].seg));
      check($sformatf("vec%0d idx", i), 32'(bus.digit_idx), 32'(vecs[i].idx));
      check($sformatf("vec%0d frame_done", i), 32'(bus.frame_done), 32'(vecs[i].fd));
    end

    // Frame 0 still shows the reset value; the pending 1234 lands at the wrap.
    check_cycles("f0", 3, N * R - 3, 16'h0000, -1, 16'h0);
    check_cycles("f1", 0, N * R, 16'h1234, -1, 16'h0);
    // Mid-frame load must not tear the current frame.
    check_cycles("f2", 0, N * R, 16'h1234, 10, 16'hABCD);
    check_cycles("f3", 0, N * R, 16'hABCD, -1, 16'h0);
    // Pending 1111 is overridden by a load on the wrap edge (bypass).
    check_cycles("f4", 0, N * R, 16'hABCD, 5, 16'h1111);
    check_cycles("f5", 0, N * R, 16'h0005, 0, 16'h0005);
    check_cycles("f6", 0, N * R, 16'h0005, -1, 16'h0);
    check_cycles("f7", 0, N * R, 16'h0050, 0, 16'h0050);
    check_cycles("f8", 0, N * R, 16'h0000, 0, 16'h0000);
    check_cycles("f9", 0, N * R, 16'h6789, 0, 16'h6789);

    // Enable drop during SHOW of digit 2.
    check_cycles("f10", 0, 2 * R + 4, 16'h6789, -1, 16'h0);
    bus.en = 1'b0;
    tick();
    check_dark("en_drop");
    tick();
    check_dark("en_low");
    bus.en = 1'b1;
    check_cycles("f11", 0, N * R, 16'h6789, -1, 16'h0);

    // Mid-operation reset clears active, shadow and pending.
    check_cycles("f12", 0, 12, 16'h6789, 3, 16'h7777);
    rst_n = 1'b0;
    tick();
    check_dark("mid_rst");
    rst_n = 1'b1;
    check_cycles("f13", 0, N * R, 16'h0000, -1, 16'h0);
    check_cycles("f14", 0, N * R, 16'h0000, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
